// File: rtl/fpga_robots_game_beeper_pkg.sv
// Shared constants for the robots game beeper: channel state encoding,
// default field widths and the standard attention length.
package fpga_robots_game_beeper_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } chan_state_t;

    localparam int DEF_DUR_W   = 5;
    localparam int DEF_DIV_W   = 8;
    localparam int ATTN_FRAMES = 30;

endpackage

// File: rtl/fpga_robots_game_beep_chan.sv
// One tone channel: square wave of programmable half-period that lasts a
// programmable number of video frames.
module fpga_robots_game_beep_chan
    import fpga_robots_game_beeper_pkg::*;
#(
    parameter int DUR_W = DEF_DUR_W,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             frame,
    input  logic             req,
    input  logic [DUR_W-1:0] req_dur,
    input  logic [DIV_W-1:0] req_div,
    output logic             active,
    output logic             ph
);

    chan_state_t      state;
    logic [DUR_W-1:0] dcnt;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] tcnt;

    assign active = (state == ST_PLAY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            dcnt  <= '0;
            div   <= '0;
            tcnt  <= '0;
            ph    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req && req_dur != '0) begin
                        state <= ST_PLAY;
                        dcnt  <= req_dur;
                        div   <= req_div;
                        tcnt  <= req_div;
                        ph    <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (req) begin
                        // retrigger keeps the phase so the tone does not click
                        if (req_dur != '0) begin
                            dcnt <= req_dur;
                            div  <= req_div;
                            tcnt <= req_div;
                        end else begin
                            state <= ST_IDLE;
                            dcnt  <= '0;
                            ph    <= 1'b0;
                        end
                    end else begin
                        if (tick) begin
                            if (tcnt == '0) begin
                                tcnt <= div;
                                ph   <= ~ph;
                            end else begin
                                tcnt <= tcnt - 1'b1;
                            end
                        end
                        if (frame && dcnt != '0) begin
                            dcnt <= dcnt - 1'b1;
                            if (dcnt == DUR_W'(1)) begin
                                state <= ST_IDLE;
                                ph    <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fpga_robots_game_beeper.sv
// Multi-channel beeper: CHANNELS tone channels mixed into one audio bit.
// FPGA_ROBOTS_BEEP_PDM_EN selects a sigma-delta mixer instead of a plain OR.
module fpga_robots_game_beeper
    import fpga_robots_game_beeper_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int DUR_W    = DEF_DUR_W,
    parameter int DIV_W    = DEF_DIV_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick,
    input  logic                      frame,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS*DUR_W-1:0] req_dur,
    input  logic [CHANNELS*DIV_W-1:0] req_div,
    output logic [CHANNELS-1:0]       active,
    output logic                      attention,
    output logic                      audio
);

    localparam int SW = 5;

    logic [CHANNELS-1:0] ph;
    logic [SW-1:0]       ones;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        fpga_robots_game_beep_chan #(
            .DUR_W(DUR_W),
            .DIV_W(DIV_W)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .tick   (tick),
            .frame  (frame),
            .req    (req[i]),
            .req_dur(req_dur[i*DUR_W +: DUR_W]),
            .req_div(req_div[i*DIV_W +: DIV_W]),
            .active (active[i]),
            .ph     (ph[i])
        );
    end

    assign attention = |active;

    always_comb begin
        ones = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ones = ones + SW'(ph[i] & active[i]);
        end
    end

`ifdef FPGA_ROBOTS_BEEP_PDM_EN
    localparam int ACC_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [ACC_W-1:0] acc;
    logic [SW-1:0]    sum;

    assign sum = SW'(acc) + ones;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            audio <= 1'b0;
        end else if (sum >= SW'(CHANNELS)) begin
            acc   <= ACC_W'(sum - SW'(CHANNELS));
            audio <= 1'b1;
        end else begin
            acc   <= ACC_W'(sum);
            audio <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            audio <= 1'b0;
        end else begin
            audio <= (ones != '0);
        end
    end
`endif

endmodule

// File: tb/tb_fpga_robots_game_beeper.sv
// Randomized bench for the beeper against a tick/frame counting model.
// Audio model follows FPGA_ROBOTS_BEEP_PDM_EN like the design.
module tb_fpga_robots_game_beeper;

    localparam int NCH   = 2;
    localparam int DUR_W = 5;
    localparam int DIV_W = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   tick;
    logic                   frame;
    logic [NCH-1:0]         req;
    logic [NCH*DUR_W-1:0]   req_dur;
    logic [NCH*DIV_W-1:0]   req_div;
    logic [NCH-1:0]         active;
    logic                   attention;
    logic                   audio;

    fpga_robots_game_beeper #(
        .CHANNELS(NCH),
        .DUR_W   (DUR_W),
        .DIV_W   (DIV_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .frame    (frame),
        .req      (req),
        .req_dur  (req_dur),
        .req_div  (req_div),
        .active   (active),
        .attention(attention),
        .audio    (audio)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model: tone described by ticks since (re)load and frames left
    bit     m_play [NCH];
    int     m_left [NCH];
    int     m_div  [NCH];
    int     m_n    [NCH];
    bit     m_base [NCH];
    longint m_tot;
    bit     m_audio;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit mph(int i);
        if (!m_play[i]) return 1'b0;
        return m_base[i] ^ bit'((m_n[i] / (m_div[i] + 1)) % 2);
    endfunction

    task automatic model_step();
        int ones;
        ones = 0;
        for (int i = 0; i < NCH; i++) ones += int'(mph(i));
        if (rst) begin
            m_tot   = 0;
            m_audio = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_play[i] = 1'b0;
                m_left[i] = 0;
                m_div[i]  = 0;
                m_n[i]    = 0;
                m_base[i] = 1'b0;
            end
            return;
        end
`ifdef FPGA_ROBOTS_BEEP_PDM_EN
        m_audio = ((m_tot + ones) / NCH) != (m_tot / NCH);
        m_tot   = m_tot + ones;
`else
        m_audio = (ones != 0);
`endif
        for (int i = 0; i < NCH; i++) begin
            int d;
            int v;
            d = int'(req_dur[i*DUR_W +: DUR_W]);
            v = int'(req_div[i*DIV_W +: DIV_W]);
            if (!m_play[i]) begin
                if (req[i] && d != 0) begin
                    m_play[i] = 1'b1;
                    m_left[i] = d;
                    m_div[i]  = v;
                    m_n[i]    = 0;
                    m_base[i] = 1'b0;
                end
            end else if (req[i]) begin
                if (d != 0) begin
                    m_base[i] = mph(i);
                    m_left[i] = d;
                    m_div[i]  = v;
                    m_n[i]    = 0;
                end else begin
                    m_play[i] = 1'b0;
                end
            end else begin
                if (tick) m_n[i]++;
                if (frame) begin
                    m_left[i]--;
                    if (m_left[i] == 0) m_play[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic compare();
        logic [NCH-1:0] ea;
        for (int i = 0; i < NCH; i++) ea[i] = m_play[i];
        check("active", 32'(active), 32'(ea));
        check("attention", 32'(attention), 32'(|ea));
        check("audio", 32'(audio), 32'(m_audio));
    endtask

    int p_tick [4] = '{25, 100, 100, 50};
    int p_frm  [4] = '{3, 5, 1, 20};
    int p_req  [4] = '{3, 5, 1, 10};
    int p_dmax [4] = '{3, 0, 2, 1};
    int p_dur  [4] = '{7, 4, 3, 2};

    initial begin
        rst     = 1'b1;
        tick    = 1'b0;
        frame   = 1'b0;
        req     = '0;
        req_dur = '0;
        req_div = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            model_step();
            #1;
            compare();
        end
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 4000; c++) begin
                rst   = ($urandom_range(0, 599) == 0);
                tick  = ($urandom_range(0, 99) < p_tick[ph]);
                frame = ($urandom_range(0, 99) < p_frm[ph]);
                for (int i = 0; i < NCH; i++) begin
                    req[i] = ($urandom_range(0, 99) < p_req[ph]);
                    if ($urandom_range(0, 4) == 0)
                        req_dur[i*DUR_W +: DUR_W] = '0;
                    else
                        req_dur[i*DUR_W +: DUR_W] =
                            DUR_W'($urandom_range(1, p_dur[ph]));
                    if ($urandom_range(0, 9) == 0)
                        req_div[i*DIV_W +: DIV_W] = 8'd255;
                    else
                        req_div[i*DIV_W +: DIV_W] =
                            DIV_W'($urandom_range(0, p_dmax[ph]));
                end
                if (rst && $urandom_range(0, 1) == 1) req = '1;
                @(posedge clk);
                model_step();
                #1;
                compare();
            end
        end
        rst   = 1'b0;
        tick  = 1'b1;
        frame = 1'b0;
        req   = '1;
        req_dur = {DUR_W'(20), DUR_W'(20)};
        req_div = {DIV_W'(0), DIV_W'(0)};
        @(posedge clk);
        model_step();
        #1;
        compare();
        req = '0;
        for (int c = 0; c < 40; c++) begin
            frame = (c == 30);
            @(posedge clk);
            model_step();
            #1;
            compare();
        end
        rst = 1'b1;
        req = '1;
        @(posedge clk);
        model_step();
        #1;
        compare();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
